// File: rtl/codec_pkg.sv
// Shared types and constants for the WM8731 codec setup hierarchy.
// Holds the request arbiter state encoding and the command word layout.
package codec_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

  localparam int I2C_CMD_W = 16;
  localparam logic [7:0] WM8731_DEV_ADDR = 8'h34;

  // Command word is {reg addr[6:0], data[8:0]}
  function automatic logic [6:0] cmd_reg_addr(input logic [I2C_CMD_W-1:0] cmd);
    return cmd[15:9];
  endfunction

  function automatic logic [8:0] cmd_reg_data(input logic [I2C_CMD_W-1:0] cmd);
    return cmd[8:0];
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest requester at or above ptr wins,
// wrapping to the lowest requester overall when nothing sits at or above ptr.
module rr_picker
  import codec_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx,
  output logic               valid
);

  logic [NUM_REQ-1:0] upper_s;
  logic [NUM_REQ-1:0] src_s;

  // Split requests into the half at/above the pointer, falling back to all of them
  always_comb begin
    upper_s = {NUM_REQ{1'b0}};
    for (int j = 0; j < NUM_REQ; j++) begin
      upper_s[j] = req[j] && (j >= int'(ptr));
    end
    if (|upper_s) begin
      src_s = upper_s;
    end else begin
      src_s = req;
    end
  end

  // Lowest set bit of the chosen half becomes the one-hot grant
  always_comb begin
    gnt   = {NUM_REQ{1'b0}};
    idx   = {PW{1'b0}};
    valid = |req;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (src_s[j]) begin
        gnt    = {NUM_REQ{1'b0}};
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C codec master between several register-write requesters,
// running the master's start/busy/done handshake and reporting done/timeout.
module i2c_req_arbiter
  import codec_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                           clk_i2c,
  input  logic                           rst_ni,
  input  logic                           en_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*I2C_CMD_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic [NUM_REQ-1:0]             err_o,
  output logic                           busy_o,
  output logic                           send_start_o,
  output logic [I2C_CMD_W-1:0]           cmd_data_o,
  input  logic                           i2c_busy_i,
  input  logic                           i2c_done_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC);
  localparam logic [PW-1:0] LAST_REQ  = PW'(NUM_REQ - 1);

  arb_state_e           state_r;
  logic [PW-1:0]        rr_ptr_r;
  logic [PW-1:0]        owner_r;
  logic [TW-1:0]        timer_r;
  logic [NUM_REQ-1:0]   gnt_r;
  logic [NUM_REQ-1:0]   done_r;
  logic [NUM_REQ-1:0]   err_r;
  logic                 busy_r;
  logic                 send_start_r;
  logic [I2C_CMD_W-1:0] cmd_data_r;

  logic [NUM_REQ-1:0]   pick_gnt_s;
  logic [PW-1:0]        pick_idx_s;
  logic                 pick_valid_s;
  logic [I2C_CMD_W-1:0] cmd_sel_s;
  logic [TW-1:0]        timer_inc_s;
  logic [PW-1:0]        rr_next_s;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_picker (
    .req   (req_i),
    .ptr   (rr_ptr_r),
    .gnt   (pick_gnt_s),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  // Command word of the requester the picker selected
  always_comb begin
    cmd_sel_s = {I2C_CMD_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt_s[i]) begin
        cmd_sel_s = req_data_i[i*I2C_CMD_W +: I2C_CMD_W];
      end else begin
        cmd_sel_s = cmd_sel_s;
      end
    end
  end

  // Saturating timer increment and the pointer value after the current owner
  always_comb begin
    if (timer_r == TIMER_MAX) begin
      timer_inc_s = timer_r;
    end else begin
      timer_inc_s = timer_r + TW'(1);
    end
    if (owner_r == LAST_REQ) begin
      rr_next_s = {PW{1'b0}};
    end else begin
      rr_next_s = owner_r + PW'(1);
    end
  end

  // Arbitration FSM; every output is a register written here
  always_ff @(posedge clk_i2c) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      rr_ptr_r     <= {PW{1'b0}};
      owner_r      <= {PW{1'b0}};
      timer_r      <= {TW{1'b0}};
      gnt_r        <= {NUM_REQ{1'b0}};
      done_r       <= {NUM_REQ{1'b0}};
      err_r        <= {NUM_REQ{1'b0}};
      busy_r       <= 1'b0;
      send_start_r <= 1'b0;
      cmd_data_r   <= {I2C_CMD_W{1'b0}};
    end else begin
      done_r <= {NUM_REQ{1'b0}};
      err_r  <= {NUM_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (en_i && pick_valid_s) begin
            state_r      <= START;
            gnt_r        <= pick_gnt_s;
            owner_r      <= pick_idx_s;
            cmd_data_r   <= cmd_sel_s;
            timer_r      <= {TW{1'b0}};
            busy_r       <= 1'b1;
            send_start_r <= 1'b1;
          end
        end
        START: begin
          if (i2c_busy_i) begin
            state_r <= WAIT_DONE;
            timer_r <= {TW{1'b0}};
          end else if (timer_inc_s == TIMER_MAX) begin
            state_r      <= RELEASE;
            err_r        <= gnt_r;
            send_start_r <= 1'b0;
            timer_r      <= timer_inc_s;
          end else begin
            timer_r <= timer_inc_s;
          end
        end
        WAIT_DONE: begin
          if (i2c_done_i) begin
            state_r      <= RELEASE;
            done_r       <= gnt_r;
            send_start_r <= 1'b0;
          end else if (timer_inc_s == TIMER_MAX) begin
            state_r      <= RELEASE;
            err_r        <= gnt_r;
            send_start_r <= 1'b0;
            timer_r      <= timer_inc_s;
          end else begin
            timer_r <= timer_inc_s;
          end
        end
        RELEASE: begin
          // Hold ownership until the master has fully let go of the bus
          if (!i2c_done_i && !i2c_busy_i) begin
            state_r  <= IDLE;
            gnt_r    <= {NUM_REQ{1'b0}};
            busy_r   <= 1'b0;
            rr_ptr_r <= rr_next_s;
          end
        end
        default: begin
          state_r      <= IDLE;
          gnt_r        <= {NUM_REQ{1'b0}};
          busy_r       <= 1'b0;
          send_start_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o        = gnt_r;
  assign done_o       = done_r;
  assign err_o        = err_r;
  assign busy_o       = busy_r;
  assign send_start_o = send_start_r;
  assign cmd_data_o   = cmd_data_r;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed scoreboard bench for i2c_req_arbiter with a small I2C master model.
module tb_i2c_req_arbiter;

  localparam int NREQ = 2;
  localparam int TOC  = 64;

  logic        clk_i2c = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [1:0]  req_i;
  logic [31:0] req_data_i;
  logic [1:0]  gnt_o;
  logic [1:0]  done_o;
  logic [1:0]  err_o;
  logic        busy_o;
  logic        send_start_o;
  logic [15:0] cmd_data_o;
  logic        i2c_busy_i;
  logic        i2c_done_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          owner;
    bit          is_err;
    logic [15:0] cmd;
    int          ss;
    int          rel;
  } exp_t;

  exp_t sb[$];

  i2c_req_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TOC)) dut (
    .clk_i2c      (clk_i2c),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .req_i        (req_i),
    .req_data_i   (req_data_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .send_start_o (send_start_o),
    .cmd_data_o   (cmd_data_o),
    .i2c_busy_i   (i2c_busy_i),
    .i2c_done_i   (i2c_done_i)
  );

  always #5 clk_i2c = ~clk_i2c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction: waits for the grant, plays the I2C master, then
  // compares what it saw against the entry at the head of the scoreboard.
  // busy_at/done_at < 0 means the master never raises that signal.
  task automatic run_txn(input int busy_at, input int done_at, input int drop_after);
    int          k = 0, low_cnt = 0, ss_cnt = 0, rel_cnt = 0, pulses = 0, cyc = 0, idle_wait = 0;
    bit          started = 1'b0, finished = 1'b0, gnt_bad = 1'b0;
    logic [1:0]  gnt_seen = 2'b00, done_seen = 2'b00, err_seen = 2'b00, gnt_end = 2'b11;
    logic [15:0] cmd_seen = 16'h0000;
    exp_t        e;
    i2c_busy_i = 1'b0;
    i2c_done_i = 1'b0;
    while (cyc < 1000 && !finished) begin
      @(negedge clk_i2c);
      cyc++;
      if (!started) begin
        if (send_start_o) begin
          started  = 1'b1;
          gnt_seen = gnt_o;
          cmd_seen = cmd_data_o;
        end else begin
          idle_wait++;
        end
      end
      if (started) begin
        if (!busy_o) begin
          finished = 1'b1;
          gnt_end  = gnt_o;
        end else begin
          if (send_start_o) ss_cnt++;
          else rel_cnt++;
          if (gnt_o !== gnt_seen) gnt_bad = 1'b1;
          if (|done_o || |err_o) begin
            if (pulses == 0) begin
              done_seen = done_o;
              err_seen  = err_o;
            end
            pulses++;
            req_i = req_i & ~(done_o | err_o);
          end
          if (send_start_o) begin
            k++;
            if (busy_at >= 0 && k == busy_at + 1) i2c_busy_i = 1'b1;
            if (busy_at >= 0 && done_at >= 0 && k == busy_at + 1 + done_at) begin
              i2c_done_i = 1'b1;
              i2c_busy_i = 1'b0;
            end
          end else begin
            low_cnt++;
            if (low_cnt == drop_after) begin
              i2c_done_i = 1'b0;
              i2c_busy_i = 1'b0;
            end
          end
        end
      end
    end
    chk("txn_finished", 32'(finished), 32'd1);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("grant_owner", 32'(gnt_seen), 32'd1 << e.owner);
      chk("cmd_data", 32'(cmd_seen), 32'(e.cmd));
      chk("grant_latency", 32'(idle_wait), 32'd0);
      chk("send_start_cycles", 32'(ss_cnt), 32'(e.ss));
      chk("release_cycles", 32'(rel_cnt), 32'(e.rel));
      chk("status_pulse_count", 32'(pulses), 32'd1);
      chk("done_pulse", 32'(done_seen), e.is_err ? 32'd0 : (32'd1 << e.owner));
      chk("err_pulse", 32'(err_seen), e.is_err ? (32'd1 << e.owner) : 32'd0);
      chk("grant_stable", 32'(gnt_bad), 32'd0);
      chk("grant_cleared", 32'(gnt_end), 32'd0);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_i2c);
    rst_ni     = 1'b0;
    i2c_busy_i = 1'b0;
    i2c_done_i = 1'b0;
    req_i      = 2'b00;
    repeat (2) @(negedge clk_i2c);
    rst_ni = 1'b1;
  endtask

  initial begin
    int viol;
    rst_ni     = 1'b0;
    en_i       = 1'b1;
    req_i      = 2'b00;
    req_data_i = 32'h0000_0000;
    i2c_busy_i = 1'b0;
    i2c_done_i = 1'b0;

    // Reset values
    repeat (3) @(negedge clk_i2c);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_done_err", 32'({done_o, err_o}), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_send_start", 32'(send_start_o), 32'd0);
    chk("rst_cmd", 32'(cmd_data_o), 32'd0);
    rst_ni = 1'b1;

    // Single request from the boot sequencer
    req_data_i = {16'h1017, 16'h0C00};
    req_i      = 2'b01;
    sb.push_back('{owner: 0, is_err: 1'b0, cmd: 16'h0C00, ss: 44, rel: 1});
    run_txn(3, 40, 1);

    // Contention with both requesters re-raising: order 0,1,0,1
    apply_reset();
    req_data_i = {16'h0C1F, 16'h0A05};
    req_i = 2'b11;
    sb.push_back('{owner: 0, is_err: 1'b0, cmd: 16'h0A05, ss: 7, rel: 1});
    run_txn(1, 5, 1);
    req_i = 2'b11;
    sb.push_back('{owner: 1, is_err: 1'b0, cmd: 16'h0C1F, ss: 11, rel: 1});
    run_txn(2, 8, 1);
    req_i = 2'b11;
    sb.push_back('{owner: 0, is_err: 1'b0, cmd: 16'h0A05, ss: 4, rel: 1});
    run_txn(0, 3, 1);
    req_i = 2'b11;
    sb.push_back('{owner: 1, is_err: 1'b0, cmd: 16'h0C1F, ss: 17, rel: 1});
    run_txn(4, 12, 1);

    // Start timeout: master never goes busy
    apply_reset();
    req_data_i = {16'h0E4A, 16'h0817};
    req_i = 2'b10;
    sb.push_back('{owner: 1, is_err: 1'b1, cmd: 16'h0E4A, ss: TOC, rel: 1});
    run_txn(-1, -1, 1);

    // Done timeout: busy stays up, RELEASE holds until it drops
    req_i = 2'b01;
    sb.push_back('{owner: 0, is_err: 1'b1, cmd: 16'h0817, ss: 3 + TOC, rel: 5});
    run_txn(2, -1, 5);

    // Enable low holds IDLE; raising it grants index 0 next cycle
    apply_reset();
    en_i  = 1'b0;
    req_i = 2'b11;
    viol  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i2c);
      if (gnt_o != 2'b00 || busy_o || send_start_o) viol++;
    end
    chk("en_low_no_grant", 32'(viol), 32'd0);
    en_i = 1'b1;
    sb.push_back('{owner: 0, is_err: 1'b0, cmd: 16'h0817, ss: 4, rel: 1});
    run_txn(1, 2, 1);

    // Reset during WAIT_DONE, then the pending request restarts from index 0
    req_i = 2'b11;
    @(negedge clk_i2c);
    chk("rr_after_en_grant", 32'(gnt_o), 32'd2);
    chk("rr_after_en_start", 32'(send_start_o), 32'd1);
    i2c_busy_i = 1'b1;
    repeat (3) @(negedge clk_i2c);
    chk("wait_done_busy", 32'({busy_o, send_start_o}), 32'd3);
    rst_ni     = 1'b0;
    i2c_busy_i = 1'b0;
    @(negedge clk_i2c);
    chk("midrst_send_start", 32'(send_start_o), 32'd0);
    chk("midrst_gnt_busy", 32'({gnt_o, busy_o}), 32'd0);
    chk("midrst_no_status", 32'({done_o, err_o}), 32'd0);
    chk("midrst_cmd", 32'(cmd_data_o), 32'd0);
    rst_ni = 1'b1;
    sb.push_back('{owner: 0, is_err: 1'b0, cmd: 16'h0817, ss: 6, rel: 1});
    run_txn(2, 3, 1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
